// File: rtl/fifo_word_reader.sv
// fifo_word_reader: drains a programmed byte count from the camera FIFO and packs it into bus words.
// Define FIFO_WORD_READER_LSB_FIRST_EN to place slot 0 in the LSB lane instead of the MSB lane.
module fifo_word_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BPW        = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int BCNT_WIDTH = 3
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic                      ABORT,
    input  logic [LEN_WIDTH-1:0]      XFER_LEN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      FIFO_REN,
    input  logic                      FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0]     FIFO_RDAT,
    input  logic                      FIFO_RDAT_EN,
    output logic [DATA_WIDTH*BPW-1:0] WORD_DAT,
    output logic                      WORD_VALID,
    input  logic                      WORD_READY,
    output logic                      WORD_LAST,
    output logic [BCNT_WIDTH-1:0]     WORD_BYTES
);
    localparam int WW = DATA_WIDTH * BPW;
    localparam logic [BCNT_WIDTH:0] BPW_C = (BCNT_WIDTH + 1)'(BPW);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LASTW, S_DONE} state_t;
    state_t state, state_n;

    logic [LEN_WIDTH-1:0]  xfer_len_q, issued, rcvd, rcvd_n;
    logic                  inflight;
    logic [BCNT_WIDTH-1:0] pack_cnt, pack_cnt_n;
    logic [WW-1:0]         pack_reg, pack_nxt;
    logic                  byte_in, last_n, word_done, load, start_go;

    function automatic int lane_lsb(input int slot);
`ifdef FIFO_WORD_READER_LSB_FIRST_EN
        return slot * DATA_WIDTH;
`else
        return (BPW - 1 - slot) * DATA_WIDTH;
`endif
    endfunction

    // The pack-room term counts the outstanding read, so a returning byte always has a slot.
    assign FIFO_REN = (state == S_RUN) && !FIFO_EMPTY && (issued < xfer_len_q)
                    && (({1'b0, pack_cnt} + {{BCNT_WIDTH{1'b0}}, inflight}) < BPW_C);

    assign BUSY     = (state == S_RUN) || (state == S_LASTW);
    assign DONE     = (state == S_DONE);
    assign start_go = (state == S_IDLE) && START && !ABORT;
    assign byte_in  = FIFO_RDAT_EN && inflight && (state == S_RUN);

    assign rcvd_n     = rcvd + LEN_WIDTH'(byte_in);
    assign pack_cnt_n = pack_cnt + BCNT_WIDTH'(byte_in);
    assign last_n     = (rcvd_n == xfer_len_q);
    assign word_done  = ({1'b0, pack_cnt_n} == BPW_C) || (last_n && (pack_cnt_n != '0));
    assign load       = (state == S_RUN) && word_done && (!WORD_VALID || WORD_READY);

    // Merge the arriving byte so a word can load in the same cycle its final byte lands.
    always_comb begin
        pack_nxt = pack_reg;
        if (byte_in) begin
            for (int i = 0; i < BPW; i++) begin
                if (pack_cnt == BCNT_WIDTH'(i))
                    pack_nxt[lane_lsb(i) +: DATA_WIDTH] = FIFO_RDAT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (START) state_n = (XFER_LEN == '0) ? S_DONE : S_RUN;
            S_RUN:   if (load && last_n) state_n = S_LASTW;
            S_LASTW: if (WORD_VALID && WORD_READY) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (ABORT)
            state_n = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            xfer_len_q <= '0;
            issued     <= '0;
            rcvd       <= '0;
            inflight   <= 1'b0;
            pack_cnt   <= '0;
            pack_reg   <= '0;
            WORD_DAT   <= '0;
            WORD_VALID <= 1'b0;
            WORD_LAST  <= 1'b0;
            WORD_BYTES <= '0;
        end else if (ABORT) begin
            issued     <= '0;
            rcvd       <= '0;
            inflight   <= 1'b0;
            pack_cnt   <= '0;
            pack_reg   <= '0;
            WORD_VALID <= 1'b0;
        end else begin
            inflight <= FIFO_REN;
            if (start_go) begin
                xfer_len_q <= XFER_LEN;
                issued     <= '0;
                rcvd       <= '0;
                pack_cnt   <= '0;
                pack_reg   <= '0;
            end else begin
                if (FIFO_REN)
                    issued <= issued + LEN_WIDTH'(1);
                rcvd <= rcvd_n;
                if (load) begin
                    pack_cnt <= '0;
                    pack_reg <= '0;
                end else begin
                    pack_cnt <= pack_cnt_n;
                    pack_reg <= pack_nxt;
                end
            end
            // Output word stays frozen until accepted; a same-cycle load keeps VALID high.
            if (load) begin
                WORD_VALID <= 1'b1;
                WORD_DAT   <= pack_nxt;
                WORD_LAST  <= last_n;
                WORD_BYTES <= pack_cnt_n;
            end else if (WORD_READY) begin
                WORD_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_reader.sv
// tb_fifo_word_reader: directed and randomized transfers through a FIFO model, checked
// against a byte-list reference that chunks the transfer into words.
module tb_fifo_word_reader;
    localparam int DW  = 8;
    localparam int BPW = 4;
    localparam int LW  = 16;
    localparam int BW  = 3;

    typedef struct packed {
        logic [DW*BPW-1:0] dat;
        logic              last;
        logic [BW-1:0]     bytes;
    } word_t;

    logic              CLK = 1'b0;
    logic              RESET_N, START, ABORT, FIFO_EMPTY, FIFO_RDAT_EN, WORD_READY;
    logic [LW-1:0]     XFER_LEN;
    logic [DW-1:0]     FIFO_RDAT;
    logic              BUSY, DONE, FIFO_REN, WORD_VALID, WORD_LAST;
    logic [DW*BPW-1:0] WORD_DAT;
    logic [BW-1:0]     WORD_BYTES;

    word_t         exp_q[$];
    logic [DW-1:0] src[$], fifo_q[$], feed_q[$];
    word_t         held;
    bit            rand_ready, hold_prev;
    int tests = 0, failed = 0;
    int ren_count, done_count, valid_cycles, ren_while_empty;
    int words_exp, words_got, feed_gap, feed_cnt;

    fifo_word_reader #(.DATA_WIDTH(DW), .BPW(BPW), .LEN_WIDTH(LW), .BCNT_WIDTH(BW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .XFER_LEN(XFER_LEN),
        .BUSY(BUSY), .DONE(DONE), .FIFO_REN(FIFO_REN), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RDAT(FIFO_RDAT), .FIFO_RDAT_EN(FIFO_RDAT_EN), .WORD_DAT(WORD_DAT),
        .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY), .WORD_LAST(WORD_LAST),
        .WORD_BYTES(WORD_BYTES)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: observe at the negedge, then answer the FIFO read just after the posedge.
    task automatic applyStimulus();
        word_t e;
        bit    ren_s;
        @(negedge CLK);
        if (FIFO_REN) begin
            ren_count++;
            if (FIFO_EMPTY) ren_while_empty++;
        end
        if (WORD_VALID) valid_cycles++;
        if (DONE) begin
            done_count++;
            checkOutput("busy_in_done", 64'(BUSY), 64'd0);
        end
        if (hold_prev) begin
            checkOutput("hold_valid", 64'(WORD_VALID), 64'd1);
            checkOutput("hold_word", 64'({WORD_DAT, WORD_LAST, WORD_BYTES}), 64'(held));
        end
        if (WORD_VALID && WORD_READY) begin
            words_got++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("word_dat", 64'(WORD_DAT), 64'(e.dat));
                checkOutput("word_last", 64'(WORD_LAST), 64'(e.last));
                checkOutput("word_bytes", 64'(WORD_BYTES), 64'(e.bytes));
            end
        end
        hold_prev = WORD_VALID && !WORD_READY;
        held      = {WORD_DAT, WORD_LAST, WORD_BYTES};
        ren_s     = FIFO_REN;
        @(posedge CLK);
        #1;
        FIFO_RDAT_EN = 1'b0;
        if (ren_s && fifo_q.size() > 0) begin
            FIFO_RDAT    = fifo_q.pop_front();
            FIFO_RDAT_EN = 1'b1;
        end
        if (feed_q.size() > 0) begin
            feed_cnt++;
            if (feed_cnt >= feed_gap) begin
                fifo_q.push_back(feed_q.pop_front());
                feed_cnt = 0;
            end
        end
        FIFO_EMPTY = (fifo_q.size() == 0);
        if (rand_ready) WORD_READY = ($urandom_range(0, 3) != 0);
    endtask

    // Reference: the src bytes chunked into BPW-byte words, the tail word short and LAST.
    task automatic beginXfer(input int len, input int preload, input int gap);
        word_t e;
        int    lane;
        fifo_q.delete();
        feed_q.delete();
        exp_q.delete();
        for (int i = 0; i < src.size(); i++) begin
            if (i < preload) fifo_q.push_back(src[i]);
            else             feed_q.push_back(src[i]);
        end
        FIFO_EMPTY = (fifo_q.size() == 0);
        feed_gap   = gap;
        feed_cnt   = 0;
        for (int w = 0; w * BPW < len; w++) begin
            e = '0;
            for (int s = 0; s < BPW && w * BPW + s < len; s++) begin
`ifdef FIFO_WORD_READER_LSB_FIRST_EN
                lane = s;
`else
                lane = BPW - 1 - s;
`endif
                e.dat[lane*DW +: DW] = src[w*BPW+s];
                e.bytes = e.bytes + 1'b1;
            end
            e.last = ((w + 1) * BPW >= len);
            exp_q.push_back(e);
        end
        words_exp = exp_q.size();
        words_got = 0;
        ren_count = 0;
        done_count = 0;
        valid_cycles = 0;
        ren_while_empty = 0;
        hold_prev = 1'b0;
        XFER_LEN = LW'(len);
        START = 1'b1;
        applyStimulus();
        START = 1'b0;
    endtask

    task automatic finishXfer(input string name, input int len, input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({name, "/done_seen"}, 64'(done_count > 0), 64'd1);
        applyStimulus();
        applyStimulus();
        checkOutput({name, "/done_once"}, 64'(done_count), 64'd1);
        checkOutput({name, "/ren_total"}, 64'(ren_count), 64'(len));
        checkOutput({name, "/words"}, 64'(words_got), 64'(words_exp));
        checkOutput({name, "/ren_while_empty"}, 64'(ren_while_empty), 64'd0);
        checkOutput({name, "/busy_idle"}, 64'(BUSY), 64'd0);
    endtask

    task automatic fillRandom(input int len);
        src.delete();
        for (int i = 0; i < len; i++) src.push_back(DW'($urandom));
    endtask

    initial begin
        int n, len;
        RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0; XFER_LEN = '0;
        FIFO_EMPTY = 1'b1; FIFO_RDAT = '0; FIFO_RDAT_EN = 1'b0; WORD_READY = 1'b1;
        rand_ready = 1'b0; hold_prev = 1'b0; feed_gap = 1; feed_cnt = 0;
        #12;
        checkOutput("rst_valid", 64'(WORD_VALID), 64'd0);
        checkOutput("rst_busy_done_ren", 64'({BUSY, DONE, FIFO_REN}), 64'd0);
        checkOutput("rst_word", 64'({WORD_DAT, WORD_LAST, WORD_BYTES}), 64'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Eight preloaded bytes, plus a START while busy that must be ignored
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(8'h11 + 8'(i));
        beginXfer(8, 8, 1);
        checkOutput("busy_after_start", 64'(BUSY), 64'd1);
        repeat (3) applyStimulus();
        START = 1'b1;
        XFER_LEN = 16'd2;
        applyStimulus();
        START = 1'b0;
        finishXfer("len8", 8, 100);

        // Short final word
        src.delete();
        for (int i = 0; i < 6; i++) src.push_back(8'hA0 + 8'(i));
        beginXfer(6, 6, 1);
        finishXfer("len6", 6, 100);

        // Sink stalled: reads stop once the output word and the pack are both full
        fillRandom(12);
        WORD_READY = 1'b0;
        beginXfer(12, 12, 1);
        n = 0;
        while (!WORD_VALID && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("hold_first_word", 64'(WORD_VALID), 64'd1);
        repeat (20) applyStimulus();
        checkOutput("hold_ren_capped", 64'(ren_count), 64'(2 * BPW));
        WORD_READY = 1'b1;
        finishXfer("hold12", 12, 200);

        // FIFO empty at START, bytes trickle in
        fillRandom(3);
        beginXfer(3, 0, 10);
        finishXfer("trickle3", 3, 200);

        // Zero length
        src.delete();
        beginXfer(0, 0, 1);
        checkOutput("zero_done", 64'(DONE), 64'd1);
        applyStimulus();
        checkOutput("zero_done_fall", 64'(DONE), 64'd0);
        repeat (3) applyStimulus();
        checkOutput("zero_done_once", 64'(done_count), 64'd1);
        checkOutput("zero_no_ren", 64'(ren_count), 64'd0);
        checkOutput("zero_no_valid", 64'(valid_cycles), 64'd0);

        // Abort with a read in flight, then a clean transfer
        fillRandom(8);
        beginXfer(8, 8, 1);
        n = 0;
        while (ren_count < 2 && n < 20) begin
            applyStimulus();
            n++;
        end
        ABORT = 1'b1;
        applyStimulus();
        ABORT = 1'b0;
        checkOutput("abort_idle", 64'({WORD_VALID, BUSY, DONE}), 64'd0);
        hold_prev = 1'b0;
        exp_q.delete();
        repeat (5) applyStimulus();
        checkOutput("abort_no_done", 64'(done_count), 64'd0);
        fillRandom(4);
        beginXfer(4, 4, 1);
        finishXfer("post_abort4", 4, 100);

        // Randomized lengths, FIFO arrival gaps and sink back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 20);
            fillRandom(len);
            beginXfer(len, $urandom_range(0, len), $urandom_range(1, 4));
            finishXfer($sformatf("rand%0d", t), len, 600);
        end
        rand_ready = 1'b0;
        WORD_READY = 1'b1;

        // Asynchronous reset mid-transfer
        fillRandom(8);
        beginXfer(8, 8, 1);
        repeat (6) applyStimulus();
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(WORD_VALID), 64'd0);
        checkOutput("arst_busy_done_ren", 64'({BUSY, DONE, FIFO_REN}), 64'd0);
        checkOutput("arst_word", 64'({WORD_DAT, WORD_LAST, WORD_BYTES}), 64'd0);
        @(posedge CLK);
        #1;
        fifo_q.delete();
        feed_q.delete();
        exp_q.delete();
        hold_prev = 1'b0;
        FIFO_RDAT_EN = 1'b0;
        FIFO_EMPTY = 1'b1;
        RESET_N = 1'b1;

        fillRandom(7);
        beginXfer(7, 7, 1);
        finishXfer("post_reset7", 7, 100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
- Read-side companion to the camera byte FIFO: drains a programmed number of bytes through the FIFO's REN/RDAT/RDAT_EN read port and packs them into bus-width words.
- Words are presented on a valid/ready stream to the SD/host writer.
- Handles the FIFO's one-cycle read latency, never overruns its own pack/output storage, and flags the final, possibly partial, word.

Parameters:
- DATA_WIDTH, 8: FIFO byte width.
- BPW, 4: bytes per output word; must be 2 or more.
- LEN_WIDTH, 16: width of the transfer length and counters.
- BCNT_WIDTH, 3: width of WORD_BYTES; must hold the value BPW.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse; latches XFER_LEN and begins a transfer; ignored while BUSY=1
- ABORT  in  1  synchronous abort; returns to IDLE
- XFER_LEN  in  LEN_WIDTH  number of bytes to drain
- BUSY  out  1  high from the cycle after START until the DONE cycle
- DONE  out  1  one-cycle pulse when the transfer completes
- FIFO_REN  out  1  FIFO read request
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_RDAT  in  DATA_WIDTH  FIFO read data
- FIFO_RDAT_EN  in  1  FIFO read data valid; arrives one cycle after an accepted REN
- WORD_DAT  out  DATA_WIDTH*BPW  packed word
- WORD_VALID  out  1  WORD_DAT holds a word
- WORD_READY  in  1  sink accepts the word when VALID and READY are both high
- WORD_LAST  out  1  word contains the final byte of the transfer
- WORD_BYTES  out  BCNT_WIDTH  number of valid bytes in WORD_DAT (BPW, except a short last word)

Behaviour:
- Reset: state IDLE. BUSY, DONE, FIFO_REN, WORD_VALID and WORD_LAST are 0. WORD_DAT is 0, WORD_BYTES is 0. All counters and pack_cnt are 0, inflight is 0.
- Reset asserted mid-transfer: all state clears immediately; any read already issued is forgotten.
- Counters:
  - issued counts REN pulses; rcvd counts RDAT_EN pulses. Both are LEN_WIDTH wide and both clear on START.
  - inflight is 1 in the cycle after REN=1, and 0 otherwise.
- FIFO_REN is a combinational output. It is 1 only when all of these hold: state RUN, FIFO_EMPTY=0, issued<XFER_LEN, and pack_cnt+inflight<BPW.
  - Because REN is never asserted while EMPTY=1, every REN is accepted and produces exactly one RDAT_EN.
  - RDAT_EN outside the RUN state is ignored.
- Packing: on each RDAT_EN, the byte is stored at slot pack_cnt and pack_cnt increments.
  - Slot 0 is the MSB lane, WORD_DAT[DATA_WIDTH*BPW-1 -: DATA_WIDTH].
  - Unfilled lanes are 0.
- Word load: a word is complete when pack_cnt reaches BPW, or when rcvd==XFER_LEN and pack_cnt>0.
  - It loads into the output register in the same cycle it completes if WORD_VALID=0, or if WORD_VALID=1 and WORD_READY=1. Otherwise it is held and loads on the first cycle the output frees.
  - On load: WORD_VALID=1, WORD_BYTES=pack_cnt, WORD_LAST=(rcvd==XFER_LEN), pack_cnt=0.
  - WORD_DAT, WORD_LAST and WORD_BYTES are stable while VALID=1 and READY=0.
  - WORD_VALID falls on acceptance unless a new word loads in the same cycle.
- Throughput: at most BPW bytes per BPW+1 cycles, with one bubble per word from the REN rule.
- FSM:
  - IDLE: START with XFER_LEN=0 → DONE for 1 cycle, then IDLE; no words are produced. START with XFER_LEN>0 → RUN.
  - RUN: when rcvd==XFER_LEN and the last word has loaded → LASTW.
  - LASTW: on acceptance of the word with WORD_LAST=1 → DONE state. That state pulses DONE=1 for one cycle, then returns to IDLE. BUSY=0 in the DONE cycle.
- ABORT, in any state: next state IDLE. WORD_VALID, pack_cnt, counters and inflight clear. No DONE pulse. A byte returning after ABORT is dropped. ABORT has priority over START.
- START during BUSY has no effect.
- Counter wrap is impossible because issued never exceeds XFER_LEN.

Optional Feature:
- Macro FIFO_WORD_READER_LSB_FIRST_EN.
- Defined: slot 0 is the LSB lane, bytes fill upward, and a partial last word occupies the low lanes.
- Undefined (default): MSB-first packing as described under Behaviour.
- Only lane placement changes; counts, flags and timing are identical in both builds.

Test Plan:
- FIFO preloaded with 0x11..0x18, XFER_LEN=8, READY tied high → two words, 0x11121314 (LAST=0, BYTES=4) then 0x15161718 (LAST=1, BYTES=4); DONE pulses once; exactly 8 REN pulses.
- XFER_LEN=6 with bytes 0xA0..0xA5 → 0xA0A1A2A3, then 0xA4A50000 with LAST=1, BYTES=2; with LSB_FIRST_EN defined, 0xA3A2A1A0 and 0x0000A5A4.
- READY held low for 20 cycles after the first word, XFER_LEN=12 → REN stops once the pack fills (4 bytes pending); WORD_DAT is stable; after release the remaining words are delivered in order; 12 REN total.
- FIFO empty at START with XFER_LEN=3, bytes written later one every 10 cycles → REN only while EMPTY=0; single word 0xXXYYZZ00 with LAST=1, BYTES=3.
- START with XFER_LEN=0 → DONE 1 cycle later, no REN, WORD_VALID stays 0; a START pulse while BUSY is ignored.
- ABORT asserted with one read in flight mid-word → next cycle IDLE, WORD_VALID=0, no DONE; a new START with XFER_LEN=4 yields a clean 4-byte word. RESET_N pulsed mid-transfer → all outputs 0 asynchronously.
